prog_mem_loader: RTL and testbench



---
 rtl/prog_mem_if.sv | 30 +++
 rtl/prog_mem_loader.sv | 154 +++++++++++++++
 tb/tb_prog_mem_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_mem_if.sv
// prog_mem_if: the two buses of the program memory loader.
//   Load port (host -> loader): ld_valid, ld_data, ld_last, with ld_ready back.
//     Valid/ready rule: a word moves on a rising clk edge where ld_valid and
//     ld_ready are both high. The host holds ld_data/ld_last stable while
//     ld_valid is high. ld_ready does not depend on ld_valid.
//   Fetch port (processor <-> loader): cpu_addr in; cpu_din and cpu_reset out.
//     cpu_reset is active-low: 0 holds the processor in reset.
// Modports: master = host/processor side, slave = loader side.
interface prog_mem_if #(
  parameter int AW = 7,
  parameter int DW = 16
);
  logic          ld_valid;
  logic          ld_ready;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_reset;

  modport master (
    output ld_valid, ld_data, ld_last, cpu_addr,
    input  ld_ready, cpu_din, cpu_reset
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, cpu_addr,
    output ld_ready, cpu_din, cpu_reset
  );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: program memory plus streaming loader for mproc.
//   A host streams a program over the load port of bus while the processor is
//   held in reset (cpu_reset=0). Once the last word is accepted the block
//   enters RUN, releases the processor and serves instruction fetches
//   combinationally (cpu_din from cpu_addr, zero latency). Overflow, or a
//   checksum mismatch when checksumming is built in, parks the block in ERR.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   restart    single-cycle pulse: abort and begin a fresh load
//   bus        prog_mem_if.slave (ld_valid/ld_ready/ld_data/ld_last,
//              cpu_addr/cpu_din/cpu_reset)
//   exp_sum    expected checksum, sampled on the ld_last accept (checksum build)
//   ld_sum     running sum of accepted words mod 2**DW (checksum build)
//   prog_len   number of words loaded, 0..DEPTH
//   running    high in RUN
//   err        high in ERR
//   state_dbg  current FSM state (LOAD=0, RUN=1, ERR=2)
// Build option: define PROG_MEM_CHECKSUM_EN to add exp_sum/ld_sum and the
//   checksum check on the final word. DEPTH must equal 2**AW.
module prog_mem_loader #(
  parameter int AW    = 7,
  parameter int DW    = 16,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          restart,
  prog_mem_if.slave     bus,
`ifdef PROG_MEM_CHECKSUM_EN
  input  logic [DW-1:0] exp_sum,
  output logic [DW-1:0] ld_sum,
`endif
  output logic [AW:0]   prog_len,
  output logic          running,
  output logic          err,
  output logic [1:0]    state_dbg
);

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [AW-1:0] WPTR_MAX = AW'(DEPTH - 1);
  localparam logic [AW:0]   LEN_MAX  = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [AW-1:0] wptr;
  logic          ld_ready_q;
  logic          cpu_reset_q;
  logic          accept;
  logic          last_ok;

  // ld_ready is only ever high in LOAD, so an accept implies LOAD.
  assign accept = bus.ld_valid && ld_ready_q;

`ifdef PROG_MEM_CHECKSUM_EN
  logic [DW-1:0] sum_q;
  logic [DW-1:0] sum_nxt;

  assign sum_nxt = sum_q + bus.ld_data;
  // The check includes the final word itself.
  assign last_ok = (sum_nxt == exp_sum);
  assign ld_sum  = sum_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q <= '0;
    end else if (restart) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_nxt;
    end
  end
`else
  assign last_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: begin
        if (accept) begin
          if (bus.ld_last) begin
            state_nxt = last_ok ? ST_RUN : ST_ERR;
          end else if (wptr == WPTR_MAX) begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_RUN:  state_nxt = ST_RUN;
      ST_ERR:  state_nxt = ST_ERR;
      default: state_nxt = ST_LOAD;
    endcase
    // restart wins over any simultaneous accept.
    if (restart) begin
      state_nxt = ST_LOAD;
    end
  end

  // ld_ready and cpu_reset are registered from the next state, so ld_ready
  // stays low through reset and rises on the first edge after release, and
  // cpu_reset rises on the edge that accepts the final word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_LOAD;
      wptr        <= '0;
      prog_len    <= '0;
      ld_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      ld_ready_q  <= (state_nxt == ST_LOAD);
      cpu_reset_q <= (state_nxt == ST_RUN);
      if (restart) begin
        wptr     <= '0;
        prog_len <= '0;
      end else if (accept) begin
        // Pointer holds at the top word; the FSM leaves LOAD on that accept.
        if (wptr != WPTR_MAX) begin
          wptr <= wptr + 1'b1;
        end
        if (prog_len != LEN_MAX) begin
          prog_len <= prog_len + 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && !restart && accept) begin
      mem[wptr] <= bus.ld_data;
    end
  end

  assign running       = (state == ST_RUN);
  assign err           = (state == ST_ERR);
  assign state_dbg     = state;
  assign bus.ld_ready  = ld_ready_q;
  assign bus.cpu_reset = cpu_reset_q;

  // Addresses past the loaded program read as 0, a harmless op for mproc.
  always_comb begin
    bus.cpu_din = '0;
    if (running && ({1'b0, bus.cpu_addr} < prog_len)) begin
      bus.cpu_din = mem[bus.cpu_addr];
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int DEPTH = 128;

  localparam int M_LOAD = 0;
  localparam int M_RUN  = 1;
  localparam int M_ERR  = 2;

  logic          clk;
  logic          reset;
  logic          restart;
  logic [AW:0]   prog_len;
  logic          running;
  logic          err;
  logic [1:0]    state_dbg;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [DW-1:0] exp_sum;
  logic [DW-1:0] ld_sum;
  bit            auto_sum;
`endif

  prog_mem_if #(.AW(AW), .DW(DW)) bus ();

  prog_mem_loader #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .bus       (bus),
`ifdef PROG_MEM_CHECKSUM_EN
    .exp_sum   (exp_sum),
    .ld_sum    (ld_sum),
`endif
    .prog_len  (prog_len),
    .running   (running),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard and reference model
  int            n_pass;
  int            n_total;
  logic [DW-1:0] m_mem [DEPTH];
  int            m_len;
  int            m_state;
  logic [DW-1:0] m_sum;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_din;
  } rd_vec_t;
  rd_vec_t rd_vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_len   = 0;
    m_state = M_LOAD;
    m_sum   = '0;
  endtask

  // Present one word for one cycle; the model applies the accept rules.
  task automatic send(input logic [DW-1:0] d, input logic last);
`ifdef PROG_MEM_CHECKSUM_EN
    if (auto_sum) exp_sum = m_sum + d;
`endif
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    if (m_state == M_LOAD) begin
      m_mem[m_len] = d;
      m_len++;
      m_sum = m_sum + d;
      if (last) begin
`ifdef PROG_MEM_CHECKSUM_EN
        m_state = (m_sum == exp_sum) ? M_RUN : M_ERR;
`else
        m_state = M_RUN;
`endif
      end else if (m_len == DEPTH) begin
        m_state = M_ERR;
      end
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_clear();
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (m_state == M_RUN && int'(a) < m_len) return m_mem[a];
    return '0;
  endfunction

  task automatic check_read(input string name, input logic [AW-1:0] a);
    bus.cpu_addr = a;
    @(negedge clk);
    check(name, 32'(bus.cpu_din), 32'(model_read(a)));
  endtask

  task automatic check_status(input string name);
    check({name, ".running"},   32'(running),       32'(m_state == M_RUN));
    check({name, ".err"},       32'(err),           32'(m_state == M_ERR));
    check({name, ".cpu_reset"}, 32'(bus.cpu_reset), 32'(m_state == M_RUN));
    check({name, ".ld_ready"},  32'(bus.ld_ready),  32'(m_state == M_LOAD));
    check({name, ".prog_len"},  32'(prog_len),      32'(m_len));
`ifdef PROG_MEM_CHECKSUM_EN
    check({name, ".ld_sum"},    32'(ld_sum),        32'(m_sum));
`endif
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b0;
    restart      = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_last  = 1'b0;
    bus.cpu_addr = '0;
`ifdef PROG_MEM_CHECKSUM_EN
    exp_sum  = '0;
    auto_sum = 1'b1;
`endif
    model_clear();

    rd_vecs[0] = '{addr: 7'd0,   exp_din: 16'h0A01};
    rd_vecs[1] = '{addr: 7'd1,   exp_din: 16'h0B02};
    rd_vecs[2] = '{addr: 7'd2,   exp_din: 16'h0C03};
    rd_vecs[3] = '{addr: 7'd3,   exp_din: 16'h0000};
    rd_vecs[4] = '{addr: 7'h7F,  exp_din: 16'h0000};

    // Reset state
    repeat (3) tick();
    check("rst.ld_ready",  32'(bus.ld_ready),  32'd0);
    check("rst.cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("rst.running",   32'(running),       32'd0);
    check("rst.err",       32'(err),           32'd0);
    check("rst.prog_len",  32'(prog_len),      32'd0);
    reset = 1'b1;
    tick();
    check_status("after_rst");

    // Three-word program, table-driven reads
    send(16'h0A01, 1'b0);
    check_status("load1");
    send(16'h0B02, 1'b0);
    send(16'h0C03, 1'b1);
    check_status("run3");
    for (int i = 0; i < 5; i++) begin
      bus.cpu_addr = rd_vecs[i].addr;
      @(negedge clk);
      check($sformatf("vec%0d.cpu_din", i), 32'(bus.cpu_din), 32'(rd_vecs[i].exp_din));
    end
    // ld_valid ignored in RUN
    send(16'hDEAD, 1'b1);
    check_status("run_ignore");

    // Full 128-word program, last on the final word
    pulse_restart();
    check_status("restart_a");
    for (int i = 0; i < DEPTH; i++) send(16'h1000 + 16'(i), (i == DEPTH - 1));
    check_status("full128");
    check_read("full128.rd7f", 7'h7F);
    check("full128.7f_const", 32'(bus.cpu_din), 32'h107F);
    check_read("full128.rd40", 7'h40);

    // 128 words without ld_last -> overflow
    pulse_restart();
    for (int i = 0; i < DEPTH; i++) send(16'h2000 + 16'(i), 1'b0);
    check_status("ovf");
    check("ovf.err_const", 32'(err), 32'd1);
    check_read("ovf.rd0", 7'd0);
    check_read("ovf.rd5", 7'd5);

    // restart colliding with a valid word in RUN
    pulse_restart();
    send(16'h5555, 1'b1);
    check_status("pre_collide");
    bus.ld_valid = 1'b1;
    bus.ld_data  = 16'hFFFF;
    bus.ld_last  = 1'b0;
    restart      = 1'b1;
    tick();
    restart      = 1'b0;
    bus.ld_valid = 1'b0;
    model_clear();
    check_status("collide");
    send(16'h1234, 1'b1);
    check_status("after_collide");
    check_read("after_collide.rd0", 7'd0);
    check("after_collide.const", 32'(bus.cpu_din), 32'h1234);
    check_read("after_collide.rd1", 7'd1);

    // Reset in the middle of a load
    pulse_restart();
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    reset = 1'b0;
    tick();
    model_clear();
    check("midrst.prog_len",  32'(prog_len),      32'd0);
    check("midrst.cpu_reset", 32'(bus.cpu_reset), 32'd0);
    check("midrst.ld_ready",  32'(bus.ld_ready),  32'd0);
    tick();
    check("midrst.ld_ready2", 32'(bus.ld_ready),  32'd0);
    reset = 1'b1;
    tick();
    check_status("midrst_rel");

`ifdef PROG_MEM_CHECKSUM_EN
    // Checksum: 0x0001 + 0xFFFF wraps to 0
    auto_sum = 1'b0;
    pulse_restart();
    exp_sum = 16'h0000;
    send(16'h0001, 1'b0);
    send(16'hFFFF, 1'b1);
    check_status("csum_ok");
    check("csum_ok.ld_sum", 32'(ld_sum), 32'd0);
    pulse_restart();
    exp_sum = 16'h0001;
    send(16'h0001, 1'b0);
    send(16'hFFFF, 1'b1);
    check_status("csum_bad");
    check("csum_bad.err", 32'(err), 32'd1);
    auto_sum = 1'b1;
`endif

    // Randomized loads against the model
    for (int it = 0; it < 6; it++) begin
      int len;
      pulse_restart();
      len = $urandom_range(1, 24);
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send(16'($urandom), (w == len - 1));
      end
      if ($urandom_range(0, 1) == 1) send(16'($urandom), 1'b0);
      check_status($sformatf("rnd%0d", it));
      for (int r = 0; r < 6; r++) begin
        check_read($sformatf("rnd%0d.rd%0d", it, r), 7'($urandom_range(0, 31)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
